// File: rtl/ai_mem_pkg.sv
// Shared types and lane helpers for the accelerator scratchpad responder.
package ai_mem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Width of the wait-state counter (WAIT_CYCLES range 0..15)
   localparam int WCNT_W = 4;

   // Byte enables moved up to the addressed lane; bytes past lane 7 drop off
   function automatic logic [7:0] lane_mask(input logic [7:0] mask, input logic [2:0] lane);
      return mask << lane;
   endfunction

   // Write data moved up to the addressed lane
   function automatic logic [63:0] lane_wdata(input logic [63:0] data, input logic [2:0] lane);
      return data << {lane, 3'b000};
   endfunction

   // Read data moved down from the addressed lane, upper bytes zero-filled
   function automatic logic [63:0] lane_rdata(input logic [63:0] word, input logic [2:0] lane);
      return word >> {lane, 3'b000};
   endfunction

endpackage

// File: rtl/ai_mem_if.sv
// Request/ready memory bus between AI compute initiators and the scratchpad.
//
// Handshake: the initiator raises mem_req with mem_we/mem_addr/mem_wdata/mem_wmask
// and holds it until it sees mem_ready. The responder samples the request once,
// in the cycle it leaves IDLE, and later pulses mem_ready for exactly one cycle;
// mem_rdata and mem_err are meaningful only while mem_ready is high. Dropping
// mem_req before mem_ready abandons the access with no side effects.
interface ai_mem_if #(
   parameter int XLEN = 64
) ();
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wmask;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;
   logic            mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_ready, mem_err
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_ready, mem_err
   );
endinterface

// File: rtl/ai_sram_1rw.sv
// Single-port SRAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module ai_sram_1rw #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH),
   localparam int NB   = XLEN / 8
) (
   input  logic            clk,
   input  logic            rd_en,
   input  logic [NB-1:0]   wr_be,
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // Byte-masked write and registered read on the shared address
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (wr_be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/ai_mem_responder.sv
// Responder side of the accelerator memory bus: captures a held request,
// waits WAIT_CYCLES, then completes a lane-aligned access to the scratchpad.
// XLEN is expected to be 64 (eight byte lanes per word).
module ai_mem_responder
   import ai_mem_pkg::*;
#(
   parameter int          XLEN        = 64,
   parameter int          DEPTH       = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   ai_mem_if.slave     bus,
   input  logic        clear_stats,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output state_t      state_dbg
);

   localparam int AW = $clog2(DEPTH);

   state_t              state, state_nxt;
   logic [WCNT_W-1:0]   cnt, cnt_nxt;
   logic                capture;

   logic                cap_we;
   logic                cap_oob;
   logic [2:0]          cap_lane;
   logic [AW-1:0]       cap_idx;
   logic [XLEN-1:0]     cap_wdata;
   logic [7:0]          cap_wmask;

   logic [XLEN-1:0]     off;
   logic                live_oob;
   logic [AW-1:0]       live_idx;

   logic                sram_rd_en;
   logic [7:0]          sram_be;
   logic [AW-1:0]       sram_addr;
   logic [XLEN-1:0]     sram_q;

   // Decode of the live bus address; only meaningful when captured in IDLE
   assign off      = bus.mem_addr - XLEN'(BASE_ADDR);
   assign live_oob = (bus.mem_addr < XLEN'(BASE_ADDR)) || ((off >> 3) >= XLEN'(DEPTH));
   assign live_idx = off[AW+2:3];

   // State and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: capture in IDLE, count down in WAIT (abort on dropped req), one RESP cycle
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_req) begin
               capture   = 1'b1;
               cnt_nxt   = WCNT_W'(WAIT_CYCLES);
               state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!bus.mem_req) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - WCNT_W'(1);
               if (cnt == WCNT_W'(1)) begin
                  state_nxt = RESP;
               end
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture; later bus changes are ignored until the next IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we    <= 1'b0;
         cap_oob   <= 1'b0;
         cap_lane  <= '0;
         cap_idx   <= '0;
         cap_wdata <= '0;
         cap_wmask <= '0;
      end else if (capture) begin
         cap_we    <= bus.mem_we;
         cap_oob   <= live_oob;
         cap_lane  <= off[2:0];
         cap_idx   <= live_idx;
         cap_wdata <= bus.mem_wdata;
         cap_wmask <= bus.mem_wmask;
      end
   end

   // The array read is launched on the cycle before RESP so the word is in the
   // output register for the whole RESP cycle. With no wait states that cycle is
   // IDLE itself, so IDLE addresses the array from the live bus.
   assign sram_rd_en = (state_nxt == RESP);
   assign sram_addr  = (state == IDLE) ? live_idx : cap_idx;
   // Writes commit on the edge that ends RESP; out-of-range writes never reach the array
   assign sram_be    = (state == RESP && cap_we && !cap_oob) ? lane_mask(cap_wmask, cap_lane) : 8'h00;

   ai_sram_1rw #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .rd_en (sram_rd_en),
      .wr_be (sram_be),
      .addr  (sram_addr),
      .wdata (lane_wdata(cap_wdata, cap_lane)),
      .rdata (sram_q)
   );

   assign bus.mem_ready = (state == RESP);
   assign bus.mem_err   = (state == RESP) && cap_oob;
   assign bus.mem_rdata = (state == RESP && !cap_we && !cap_oob) ? lane_rdata(sram_q, cap_lane) : '0;
   assign state_dbg     = state;

   // Completed in-range access statistics; clear_stats wins over an increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (clear_stats) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (state == RESP && !cap_oob) begin
         if (cap_we) begin
            wr_count <= wr_count + 16'd1;
         end else begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ai_mem_responder.sv
// Scoreboard bench for ai_mem_responder: two instances (2 and 0 wait states)
// driven from one initiator, checked against a byte-addressed reference model.
module tb_ai_mem_responder;
   import ai_mem_pkg::*;

   localparam logic [63:0] BASE  = 64'h1000;
   localparam int          DEPTH = 1024;
   localparam int          WIN   = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // initiator signals, steered to one instance by sel (0: 2 waits, 1: 0 waits)
   logic        sel   = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [63:0] addr  = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  wmask = '0;
   logic        clear = 1'b0;

   ai_mem_if #(.XLEN(64)) bus2 ();
   ai_mem_if #(.XLEN(64)) bus0 ();

   assign bus2.mem_req   = req & ~sel;
   assign bus2.mem_we    = we;
   assign bus2.mem_addr  = addr;
   assign bus2.mem_wdata = wdata;
   assign bus2.mem_wmask = wmask;
   assign bus0.mem_req   = req & sel;
   assign bus0.mem_we    = we;
   assign bus0.mem_addr  = addr;
   assign bus0.mem_wdata = wdata;
   assign bus0.mem_wmask = wmask;

   logic [15:0] rd2, wr2, rd0, wr0;
   state_t      st2, st0;

   ai_mem_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .clear_stats(clear & ~sel),
      .rd_count(rd2), .wr_count(wr2), .state_dbg(st2)
   );

   ai_mem_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .clear_stats(clear & sel),
      .rd_count(rd0), .wr_count(wr0), .state_dbg(st0)
   );

   logic        mon_ready, mon_err;
   logic [63:0] mon_rdata;
   logic [15:0] rd_mux, wr_mux;
   state_t      st_mux;
   assign mon_ready = sel ? bus0.mem_ready : bus2.mem_ready;
   assign mon_err   = sel ? bus0.mem_err   : bus2.mem_err;
   assign mon_rdata = sel ? bus0.mem_rdata : bus2.mem_rdata;
   assign rd_mux    = sel ? rd0 : rd2;
   assign wr_mux    = sel ? wr0 : wr2;
   assign st_mux    = sel ? st0 : st2;

   // ---------------- reference model and scoreboard ----------------
   logic [7:0]  mdl [2][WIN*8];        // bytes of the test window, per instance
   int unsigned m_rd [2];
   int unsigned m_wr [2];
   logic [65:0] exp_q [$];             // {is_write, err, rdata}
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Byte i of an access lands on byte (lane+i) of the word; beyond byte 7 it is lost.
   function automatic logic [64:0] model_access(input int s, input logic w, input logic [63:0] a,
                                                input logic [63:0] d, input logic [7:0] m);
      logic [63:0] off;
      logic [63:0] rd;
      int          lane;
      int          wb;
      off = a - BASE;
      if (a < BASE || off / 8 >= DEPTH) return {1'b1, 64'h0};
      lane = int'(off % 8);
      wb   = int'(off - off % 8);
      rd   = '0;
      for (int i = 0; i < 8; i++) begin
         if (lane + i < 8) begin
            if (w) begin
               if (m[i]) mdl[s][wb + lane + i] = d[8*i +: 8];
            end else begin
               rd[8*i +: 8] = mdl[s][wb + lane + i];
            end
         end
      end
      if (w) m_wr[s]++;
      else   m_rd[s]++;
      return {1'b0, rd};
   endfunction

   // Monitor: every response is popped and compared; outside a response outputs must be 0
   logic [65:0] mon_e;
   always @(negedge clk) begin
      if (mon_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: actual=1 expected=0 (no access pending)");
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_err", 66'(mon_err), 66'(mon_e[64]));
            if (!mon_e[65]) check("resp_rdata", 66'(mon_rdata), 66'(mon_e[63:0]));
         end
      end else begin
         check("idle_outputs", {mon_err, mon_rdata}, 66'h0);
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] m, input bit clr_at_ready = 1'b0);
      int          cyc;
      bit          got;
      logic [64:0] e;
      int          s;
      s = int'(sel);
      e = model_access(s, w, a, d, m);
      exp_q.push_back({w, e});
      req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         if (mon_ready) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      if (got) begin
         check("latency", 66'(cyc), sel ? 66'd1 : 66'd3);
         if (clr_at_ready) begin
            clear = 1'b1;
            m_rd[s] = 0;
            m_wr[s] = 0;
         end
         @(posedge clk);
         #1;
         clear = 1'b0;
      end else begin
         checks++;
         errors++;
         $display("FAIL latency_timeout: actual=no ready expected=ready within 40 cycles");
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      we  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_rd_count"}, 66'(rd_mux), 66'(16'(m_rd[sel])));
      check({tag, "_wr_count"}, 66'(wr_mux), 66'(16'(m_wr[sel])));
   endtask

   task automatic rand_access(input int oob_pct);
      logic [63:0] a;
      if ($urandom_range(0, 99) < oob_pct) begin
         if ($urandom_range(0, 1) == 1) a = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 4095));
         else                           a = BASE - 64'($urandom_range(1, 64));
      end else begin
         a = BASE + 64'(8 * $urandom_range(0, WIN - 1)) + 64'($urandom_range(0, 7));
      end
      access(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready2", 66'(bus2.mem_ready), 66'd0);
      check("rst_out2",   {bus2.mem_err, bus2.mem_rdata}, 66'd0);
      check("rst_cnt2",   66'({rd2, wr2}), 66'd0);
      check("rst_state2", 66'(st2), 66'(IDLE));
      check("rst_ready0", 66'(bus0.mem_ready), 66'd0);
      check("rst_cnt0",   66'({rd0, wr0}), 66'd0);
      check("rst_state0", 66'(st0), 66'(IDLE));
      rst_n = 1'b1;
      idle(1);

      // aligned write then read, 2 wait states
      access(1'b1, BASE + 64'h10, 64'h1122334455667788, 8'hFF);
      access(1'b0, BASE + 64'h10, 64'h0, 8'h00);
      idle(1);
      check_counts("aligned");

      // known contents for the whole window
      for (int i = 0; i < WIN; i++) access(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
      idle(1);

      // lane writes and reads
      access(1'b1, BASE + 64'h14, 64'h3F800000, 8'h0F);
      access(1'b1, BASE + 64'h10, 64'hDEADBEEF, 8'h0F);
      access(1'b0, BASE + 64'h10, 64'h0, 8'h00);
      access(1'b0, BASE + 64'h14, 64'h0, 8'h00);
      idle(1);
      check_counts("lane");

      // out of range: write past the end, read below base; word 0 aliases the write index
      access(1'b1, BASE + 64'(8 * DEPTH), 64'hA5A5A5A5A5A5A5A5, 8'hFF);
      idle(1);
      check_counts("oob_write");
      access(1'b0, BASE, 64'h0, 8'h00);
      access(1'b0, BASE - 64'd8, 64'h0, 8'h00);
      idle(1);
      check_counts("oob_read");

      // abort: drop request while waiting
      req = 1'b1; we = 1'b1; addr = BASE + 64'h28; wdata = 64'hFFFF0000FFFF0000; wmask = 8'hFF;
      @(posedge clk);
      #1;
      check("abort_state", 66'(st_mux), 66'(WAIT));
      req = 1'b0;
      begin
         int seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (mon_ready) seen++;
         end
         check("abort_no_ready", 66'(seen), 66'd0);
      end
      @(posedge clk);
      #1;
      access(1'b0, BASE + 64'h28, 64'h0, 8'h00);
      idle(1);
      check_counts("abort");

      // reset during the wait of a write
      req = 1'b1; we = 1'b1; addr = BASE + 64'h20; wdata = 64'h0123456789ABCDEF; wmask = 8'hFF;
      @(posedge clk);
      #1;
      check("rstw_state", 66'(st_mux), 66'(WAIT));
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      check("rstw_outs",  {mon_ready, mon_err, mon_rdata}, 66'd0);
      check("rstw_state_idle", 66'(st_mux), 66'(IDLE));
      for (int s = 0; s < 2; s++) begin
         m_rd[s] = 0;
         m_wr[s] = 0;
      end
      check_counts("rstw");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      access(1'b0, BASE + 64'h20, 64'h0, 8'h00);
      idle(1);
      check_counts("after_rst");

      // random traffic, 2 wait states
      for (int i = 0; i < 60; i++) begin
         rand_access(10);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
      check_counts("rand2");

      // ---------------- zero wait states ----------------
      idle(2);
      sel = 1'b1;
      idle(1);
      for (int i = 0; i < WIN; i++) access(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
      for (int i = 0; i < 40; i++) rand_access(10);
      idle(1);
      check_counts("rand0");

      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      m_rd[1] = 0;
      m_wr[1] = 0;
      check_counts("clear");

      for (int i = 0; i < 5; i++) access(1'b0, BASE + 64'(8 * $urandom_range(0, WIN - 1)), 64'h0, 8'h00);
      idle(1);
      check_counts("stream5");
      for (int i = 0; i < 5; i++) access(1'b0, BASE + 64'(8 * i + 4), 64'h0, 8'h00, i == 4);
      idle(1);
      check_counts("stream_clear");

      idle(3);
      check("queue_empty", 66'(exp_q.size()), 66'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: actual=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
